mc_cpu_core: RTL

Parametrised multi-cycle MIPS-subset core; the successor to the single-cycle CPU top. It breaks each instruction into FETCH/DECODE/EXEC/MEM/WB states driven by a central FSM. It holds the architectural state internally (PC, 32×32 register file, IR/MDR/A/B/ALUOut) and reaches one unified instruction/data memory through a single req/ready port, so multi-cycle memories plug in directly.

---
 rtl/mc_cpu_core_if.sv | 25 ++
 rtl/mc_cpu_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu_core_if.sv
// Unified instruction/data memory port for mc_cpu_core.
//   mem_req    core -> mem   transfer request valid
//   mem_we     core -> mem   1 = write, 0 = read; valid with mem_req
//   mem_addr   core -> mem   word-aligned byte address
//   mem_wdata  core -> mem   store data
//   mem_ready  mem  -> core  transfer completes on an edge with mem_req & mem_ready
//   mem_rdata  mem  -> core  read data, valid with mem_ready
interface mc_cpu_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq, addi, j).
// Each instruction walks FETCH/DECODE/EXEC/MEM/WB under one FSM and shares a
// single req/ready memory port for instruction and data traffic.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   bus      memory master port (see mc_cpu_core_if)
//   pc       current PC
//   inst     instruction register
//   halted   core parked in HALT
//   retired  retired-instruction count, wraps at 2^32
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | read mem[PC] into IR, PC += 4 (waits for mem_ready)
// DECODE | latch A/B from rs/rt, precompute branch target into ALUOut
// EXEC   | ALU op / address calc; beq and j finish here
// MEM    | data access at ALUOut; lw writes rt as the read completes
// WB     | register write-back (R-type rd, addi rt, lw rt from MDR)
// HALT   | parked after an illegal instruction; only reset leaves
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_cpu_core_if.master        bus,
    output logic [31:0]          pc,
    output logic [31:0]          inst,
    output logic                 halted,
    output logic [31:0]          retired
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] regs_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] rs_val, rt_val;
    logic        funct_ok;
    logic        legal;
    logic [31:0] alu_r;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    // $0 is never written, but force zero anyway so the read path is obvious.
    assign rs_val = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs_q[rt];

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE:                             legal = funct_ok;
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW:  legal = 1'b1;
            default:                              legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_r = 32'd0;
        case (funct)
            FN_ADD:  alu_r = a_q + b_q;
            FN_SUB:  alu_r = a_q - b_q;
            FN_AND:  alu_r = a_q & b_q;
            FN_OR:   alu_r = a_q | b_q;
            FN_SLT:  alu_r = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            default: alu_r = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;
        retire    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d       = rs_val;
                b_d       = rt_val;
                // pc_q already points past this instruction
                alu_out_d = pc_q + {imm_sext[29:0], 2'b00};
                if (legal) begin
                    state_d = ST_EXEC;
                end else if (HALT_ON_ILLEGAL) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_out_d = alu_r;
                        state_d   = ST_WB;
                    end
                    OP_ADDI: begin
                        alu_out_d = a_q + imm_sext;
                        state_d   = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_out_d = a_q + imm_sext;
                        state_d   = ST_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = alu_out_q;
                        end
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (opcode == OP_LW) begin
                        // Load data lands in rt right away and is kept in MDR;
                        // WB rewrites the same value, giving lw its fifth cycle.
                        rf_we    = 1'b1;
                        rf_waddr = rt;
                        rf_wdata = bus.mem_rdata;
                        mdr_d    = bus.mem_rdata;
                        state_d  = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_out_q;
                state_d  = ST_FETCH;
                retire   = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        retired_d = retired_q + {31'd0, retire};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
            mdr_q     <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            retired_q <= retired_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Bus outputs depend only on registered state, so they hold steady while
    // the FSM waits on mem_ready.
    assign bus.mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign bus.mem_we    = (state_q == ST_MEM) && (opcode == OP_SW);
    assign bus.mem_addr  = (state_q == ST_MEM) ? alu_out_q : pc_q;
    assign bus.mem_wdata = b_q;

    assign pc      = pc_q;
    assign inst    = ir_q;
    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

endmodule
